// File: rtl/instr_encoder.sv
// Packs decoded field bundles into RV32I words and streams them into instruction memory.
// Optional build macro INSTR_ENC_RANGE_CHECK_EN adds immediate range/alignment error flagging.
module instr_encoder #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_alu_ctrl,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic              done,
    output logic [ADDR_W-2:0] word_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_R    = 7'b0110011;
    localparam logic [6:0]  OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;
    localparam logic [6:0]  OP_ST   = 7'b0100011;
    localparam logic [6:0]  OP_BR   = 7'b1100011;
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;
    localparam logic [6:0]  OP_LUI  = 7'b0110111;
    localparam logic [6:0]  OP_AUI  = 7'b0010111;

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [ADDR_W-2:0] word_cnt_q, word_cnt_d;
    logic              last_taken_q, last_taken_d;

    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        alu_bad;
    logic        is_shift;
    logic [11:0] imm_alu;
    logic [31:0] enc_word;
    logic        enc_bad;
    logic        range_bad;
    logic        accept;
    logic        wr_done;

    always_comb begin
        alu_f3  = 3'b000;
        alu_f7  = 7'b0000000;
        alu_bad = 1'b0;
        case (in_alu_ctrl)
            4'd0: alu_f3 = 3'b000;
            4'd1: alu_f7 = 7'b0100000;
            4'd2: alu_f3 = 3'b100;
            4'd3: alu_f3 = 3'b110;
            4'd4: alu_f3 = 3'b111;
            4'd5: alu_f3 = 3'b001;
            4'd6: alu_f3 = 3'b101;
            4'd7: begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; end
            4'd8: alu_f3 = 3'b010;
            4'd9: alu_f3 = 3'b011;
            default: alu_bad = 1'b1;
        endcase
    end

    // Immediate shifts carry funct7 in imm[11:5] and only a 5-bit shamt.
    assign is_shift = (in_alu_ctrl == 4'd5) || (in_alu_ctrl == 4'd6) || (in_alu_ctrl == 4'd7);
    assign imm_alu  = is_shift ? {alu_f7, in_imm[4:0]} : in_imm[11:0];

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (in_op)
            4'd0: if (alu_bad) enc_bad = 1'b1;
                  else enc_word = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, OP_R};
            4'd1: if (alu_bad || in_alu_ctrl == 4'd1) enc_bad = 1'b1;
                  else enc_word = {imm_alu, in_rs1, alu_f3, in_rd, OP_IMM};
            4'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            4'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_ST};
            4'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], OP_BR};
            4'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            4'd6: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            4'd7: enc_word = {in_imm[31:12], in_rd, OP_LUI};
            4'd8: enc_word = {in_imm[31:12], in_rd, OP_AUI};
            default: enc_bad = 1'b1;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic fit12, fit13, fit21;
    assign fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        range_bad = 1'b0;
        case (in_op)
            4'd1, 4'd2, 4'd3, 4'd6: range_bad = ~fit12;
            4'd4:                   range_bad = ~fit13 | in_imm[0];
            4'd5:                   range_bad = ~fit21 | in_imm[0];
            4'd7, 4'd8:             range_bad = |in_imm[11:0];
            default:                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign in_ready = (state_q == S_RUN) & ~last_taken_q & (~mem_we_q | mem_ready);
    assign accept   = in_valid & in_ready;
    assign wr_done  = mem_we_q & mem_ready;

    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;
        done_d       = 1'b0;
        word_cnt_d   = word_cnt_q;
        last_taken_d = last_taken_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d      = S_RUN;
                mem_addr_d   = base_addr & ~ADDR_W'(3);
                word_cnt_d   = '0;
                err_d        = 1'b0;
                last_taken_d = 1'b0;
            end
            S_RUN: begin
                if (wr_done) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = mem_addr_q + ADDR_W'(4);
                    word_cnt_d = word_cnt_q + 1'b1;
                end
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_wdata_d  = enc_word;
                    err_d        = err_q | enc_bad | range_bad;
                    last_taken_d = in_last;
                end
                if (last_taken_q && wr_done) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            word_cnt_q   <= '0;
            last_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            done_q       <= done_d;
            word_cnt_q   <= word_cnt_d;
            last_taken_q <= last_taken_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;
    assign done      = done_q;
    assign word_cnt  = word_cnt_q;
endmodule
